// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;
    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_WB,
        REQ_MDU,
        REQ_DBG
    } req_e;

    localparam int REG_AW           = 5;
    localparam int REG_DW           = 32;
    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-request and register-file write-port bundle between requesters and the arbiter.
interface rf_write_arbiter_if;
    import rf_arb_pkg::*;

    logic              wb_we;
    logic [REG_AW-1:0] wb_wa;
    logic [REG_DW-1:0] wb_wd;
    logic              mdu_valid;
    logic [REG_AW-1:0] mdu_wa;
    logic [REG_DW-1:0] mdu_wd;
    logic              mdu_ready;
    logic              dbg_valid;
    logic [REG_AW-1:0] dbg_wa;
    logic [REG_DW-1:0] dbg_wd;
    logic              dbg_ready;
    logic              we3;
    logic [REG_AW-1:0] wa3;
    logic [REG_DW-1:0] wd3;
    logic              stall_req;

    modport slave (
        input  wb_we, wb_wa, wb_wd,
        input  mdu_valid, mdu_wa, mdu_wd,
        input  dbg_valid, dbg_wa, dbg_wd,
        output mdu_ready, dbg_ready,
        output we3, wa3, wd3, stall_req
    );

    modport master (
        output wb_we, wb_wa, wb_wd,
        output mdu_valid, mdu_wa, mdu_wd,
        output dbg_valid, dbg_wa, dbg_wd,
        input  mdu_ready, dbg_ready,
        input  we3, wa3, wd3, stall_req
    );
endinterface

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin between the mdu and debug requesters.
module rf_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_mdu,
    input  logic req_dbg,
    output logic gnt_mdu,
    output logic gnt_dbg
);
    logic ptr_dbg;  // 0: mdu wins a tie, 1: dbg wins a tie

    always_comb begin
        gnt_mdu = 1'b0;
        gnt_dbg = 1'b0;
        if (en) begin
            if (req_mdu && (!req_dbg || !ptr_dbg))
                gnt_mdu = 1'b1;
            else if (req_dbg)
                gnt_dbg = 1'b1;
        end
    end

    // A grant is only issued to a valid requester, so every grant is a transfer.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_dbg <= 1'b0;
        else if (gnt_mdu)
            ptr_dbg <= 1'b1;
        else if (gnt_dbg)
            ptr_dbg <= 1'b0;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has absolute priority, mdu/dbg share the
// remaining slots round-robin, with a starvation counter that requests a WB bubble.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    rf_write_arbiter_if.slave bus
);
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic              gnt_mdu, gnt_dbg;
    req_e              src;
    logic [REG_AW-1:0] sel_wa;
    logic [REG_DW-1:0] sel_wd;
    logic [CW-1:0]     cnt, cnt_nxt;

    rf_rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .en      (!rst && !bus.wb_we),
        .req_mdu (bus.mdu_valid),
        .req_dbg (bus.dbg_valid),
        .gnt_mdu (gnt_mdu),
        .gnt_dbg (gnt_dbg)
    );

    assign bus.mdu_ready = gnt_mdu;
    assign bus.dbg_ready = gnt_dbg;

    always_comb begin
        src = REQ_NONE;
        if (!rst && bus.wb_we) src = REQ_WB;
        else if (gnt_mdu)      src = REQ_MDU;
        else if (gnt_dbg)      src = REQ_DBG;
    end

    always_comb begin
        sel_wa = bus.wb_wa;
        sel_wd = bus.wb_wd;
        case (src)
            REQ_MDU: begin sel_wa = bus.mdu_wa; sel_wd = bus.mdu_wd; end
            REQ_DBG: begin sel_wa = bus.dbg_wa; sel_wd = bus.dbg_wd; end
            default: ;
        endcase
    end

    // Counts consecutive cycles where a low-priority request is pending but unserved.
    always_comb begin
        cnt_nxt = cnt;
        if (gnt_mdu || gnt_dbg || !(bus.mdu_valid || bus.dbg_valid))
            cnt_nxt = '0;
        else if (cnt != LIMIT)
            cnt_nxt = cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.we3       <= 1'b0;
            bus.wa3       <= '0;
            bus.wd3       <= '0;
            bus.stall_req <= 1'b0;
            cnt           <= '0;
        end else begin
            cnt           <= cnt_nxt;
            bus.stall_req <= (cnt_nxt == LIMIT);
            if (src != REQ_NONE) begin
                bus.we3 <= (sel_wa != '0);  // r0 writes complete the handshake but are dropped
                bus.wa3 <= sel_wa;
                bus.wd3 <= sel_wd;
            end else begin
                bus.we3 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1ns after the edge with registered outputs settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational ready settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
        bus.mdu_valid = 0; bus.mdu_wa = 0; bus.mdu_wd = 0;
        bus.dbg_valid = 0; bus.dbg_wa = 0; bus.dbg_wd = 0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // Requesters held valid across reset.
        bus.mdu_valid = 1; bus.mdu_wa = 5'd3; bus.mdu_wd = 32'h33;
        bus.dbg_valid = 1; bus.dbg_wa = 5'd7; bus.dbg_wd = 32'h77;
        tick(); tick();
        chk("rst_we3", bus.we3, 0);
        chk("rst_wa3", bus.wa3, 0);
        chk("rst_wd3", bus.wd3, 0);
        chk("rst_stall", bus.stall_req, 0);
        chk("rst_mdu_rdy", bus.mdu_ready, 0);
        chk("rst_dbg_rdy", bus.dbg_ready, 0);

        // Contention: mdu, dbg, mdu, dbg
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_mdu_rdy", bus.mdu_ready, (i % 2 == 0));
            chk("rr_dbg_rdy", bus.dbg_ready, (i % 2 == 1));
            tick();
            chk("rr_we3", bus.we3, 1);
            chk("rr_wa3", bus.wa3, (i % 2 == 0) ? 32'd3 : 32'd7);
            chk("rr_wd3", bus.wd3, (i % 2 == 0) ? 32'h33 : 32'h77);
        end
        idle();
        tick();
        chk("hold_we3", bus.we3, 0);
        chk("hold_wa3", bus.wa3, 7);
        chk("hold_wd3", bus.wd3, 32'h77);

        // WB-only, with mdu also asking: WB wins, no ready
        bus.wb_we = 1; bus.wb_wa = 5'd5; bus.wb_wd = 32'hDEAD_BEEF;
        bus.mdu_valid = 1; bus.mdu_wa = 5'd1; bus.mdu_wd = 32'h11;
        settle();
        chk("wb_mdu_rdy", bus.mdu_ready, 0);
        chk("wb_dbg_rdy", bus.dbg_ready, 0);
        tick();
        chk("wb_we3", bus.we3, 1);
        chk("wb_wa3", bus.wa3, 5);
        chk("wb_wd3", bus.wd3, 32'hDEAD_BEEF);

        // WB to r0 is dropped
        idle();
        bus.wb_we = 1; bus.wb_wa = 5'd0; bus.wb_wd = 32'h55;
        tick();
        chk("wb_r0_we3", bus.we3, 0);

        // dbg r0 write: handshake completes, write dropped
        idle();
        bus.dbg_valid = 1; bus.dbg_wa = 5'd0; bus.dbg_wd = 32'h1;
        settle();
        chk("r0_dbg_rdy", bus.dbg_ready, 1);
        tick();
        chk("r0_we3", bus.we3, 0);
        idle();
        tick();

        // Starvation: mdu denied by WB for 6 cycles
        bus.wb_we = 1; bus.wb_wa = 5'd9; bus.wb_wd = 32'h99;
        bus.mdu_valid = 1; bus.mdu_wa = 5'd4; bus.mdu_wd = 32'h44;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("stv_mdu_rdy", bus.mdu_ready, 0);
            tick();
            chk("stv_stall", bus.stall_req, (i >= 3));
            chk("stv_we3", bus.we3, 1);
        end
        bus.wb_we = 0;
        settle();
        chk("stv_srv_rdy", bus.mdu_ready, 1);
        chk("stv_stall_hold", bus.stall_req, 1);
        tick();
        chk("stv_srv_wa3", bus.wa3, 4);
        chk("stv_srv_wd3", bus.wd3, 32'h44);
        chk("stv_clr", bus.stall_req, 0);

        // Mid-operation reset: mdu transfer at t (pointer now favours dbg), rst at t+1
        idle();
        bus.mdu_valid = 1; bus.mdu_wa = 5'd2; bus.mdu_wd = 32'h22;
        settle();
        chk("mr_mdu_rdy", bus.mdu_ready, 1);
        tick();
        chk("mr_we3_t1", bus.we3, 1);
        rst = 1'b1;
        settle();
        chk("mr_rst_rdy", bus.mdu_ready, 0);
        tick();
        chk("mr_we3_t2", bus.we3, 0);
        chk("mr_wa3", bus.wa3, 0);
        chk("mr_wd3", bus.wd3, 0);
        chk("mr_stall", bus.stall_req, 0);
        rst = 1'b0;
        bus.dbg_valid = 1; bus.dbg_wa = 5'd6; bus.dbg_wd = 32'h66;
        settle();
        chk("mr_ptr_mdu", bus.mdu_ready, 1);
        chk("mr_ptr_dbg", bus.dbg_ready, 0);
        tick();
        chk("mr_post_wa3", bus.wa3, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 4, the consecutive denied cycles after which a stall is requested.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-003 SHALL have wb_we  input  1  writeback-stage write request, no backpressure.
REQ-004 SHALL have wb_wa  input  5  writeback-stage destination register.
REQ-005 SHALL have wb_wd  input  32  writeback-stage write data.
REQ-006 SHALL have mdu_valid  input  1, mdu_wa  input  5 and mdu_wd  input  32, the multi-cycle unit result request.
REQ-007 SHALL have mdu_ready  output  1, the multi-cycle unit accept signal.
REQ-008 SHALL have dbg_valid  input  1, dbg_wa  input  5 and dbg_wd  input  32, the debug-host write request.
REQ-009 SHALL have dbg_ready  output  1, the debug-host accept signal.
REQ-010 SHALL have we3  output  1, wa3  output  5 and wd3  output  32, the register-file write port (registered).
REQ-011 SHALL have stall_req  output  1, a request for the pipeline to insert a writeback bubble.

Function
REQ-012 SHALL give wb_we absolute priority: wb_we=1 grants WB; mdu_ready=dbg_ready=0 that cycle.
REQ-013 SHALL, with wb_we=0, grant one of mdu/dbg by 2-way round-robin; a requester that is the only one valid wins regardless of pointer.
REQ-014 SHALL drive mdu_ready/dbg_ready combinationally in the same cycle; a transfer occurs on valid&&ready; ready SHALL NOT depend on the same requester's wa/wd.
REQ-015 SHALL assert ready only to the granted requester, and only when its valid=1.
REQ-016 SHALL move the RR pointer to the other low-priority requester only on a completed mdu or dbg transfer; WB grants leave it unchanged.
REQ-017 SHALL set the RR pointer to favour mdu out of reset.
REQ-018 SHALL register the granted request; we3/wa3/wd3 appear exactly 1 cycle after grant.
REQ-019 SHALL make we3=1 only when the granted wa is non-zero; r0 writes are accepted (handshake completes) and dropped.
REQ-020 SHALL hold we3=0 in any cycle following no grant; wa3/wd3 then hold their last values.
REQ-021 SHALL count consecutive cycles in which (mdu_valid||dbg_valid) is 1 and no low-priority transfer occurs; counter saturates at STARVE_LIMIT.
REQ-022 SHALL clear the counter on any low-priority transfer, or when both mdu_valid and dbg_valid are 0.
REQ-023 SHALL drive stall_req=1 as a registered output exactly when counter==STARVE_LIMIT.
REQ-024 SHALL let WB still win if wb_we=1 while stall_req=1, keeping stall_req asserted.
REQ-025 SHALL never perform more than one transfer per cycle.
REQ-026 SHALL size the counter as $clog2(STARVE_LIMIT+1) bits.

Reset
REQ-027 SHALL, while rst=1, force we3=0, wa3=0, wd3=0, stall_req=0, counter=0, RR pointer=mdu, mdu_ready=0 and dbg_ready=0.
REQ-028 SHALL complete no transfer in a cycle with rst=1; a requester held valid across reset is served normally afterwards.
REQ-029 SHALL cancel a write registered in the cycle before rst rises; we3=0 is observed the cycle after rst.

Structure
REQ-030 SHALL place in package rf_arb_pkg: the requester enum (REQ_NONE, REQ_WB, REQ_MDU, REQ_DBG), the REG_AW=5 and REG_DW=32 constants, and the STARVE_LIMIT default.
REQ-031 SHALL implement the 2-way round-robin pointer and grant as sub-module rf_rr_arb2; priority, output registers and starvation counter stay in the top.

Verification
REQ-032 SHALL cover WB-only: wb_we=1, wa=5, wd=32'hDEAD_BEEF -> next cycle we3=1, wa3=5, wd3=32'hDEAD_BEEF; mdu_ready=dbg_ready=0.
REQ-033 SHALL cover contention: mdu and dbg valid continuously, wb_we=0 -> grants alternate mdu, dbg, mdu, dbg starting with mdu after reset.
REQ-034 SHALL cover r0 drop: dbg_valid=1, dbg_wa=0, dbg_wd=32'h1 -> dbg_ready=1 that cycle, we3 stays 0.
REQ-035 SHALL cover starvation: wb_we=1 and mdu_valid=1 for 6 cycles, STARVE_LIMIT=4 -> stall_req rises after the 4th denied cycle; wb_we=0 -> mdu served, stall_req=0 the cycle after.
REQ-036 SHALL cover mid-operation reset: mdu transfer at cycle t, rst=1 at t+1 -> we3=0 at t+2, all outputs 0, pointer=mdu.
